// File: rtl/excess3_digit_sequencer.sv
// Feeds a packed multi-digit Excess-3 word, one digit at a time, LSB first, through an external
// bit-serial Excess-3-to-BCD converter. Collects the returned bits into a packed BCD result.
module excess3_digit_sequencer #(
    parameter int DIGITS = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_e3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [DIGITS-1:0]     out_err,
    output logic                  busy,
    output logic                  Cv_X,
    output logic                  Cv_Rst,
    input  logic                  Cv_Z
);

    localparam int W  = 4 * DIGITS;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CRST  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   d_q, d_d;
    logic [1:0]      b_q, b_d;
    logic [W-1:0]    word_q, word_d;
    logic [W-1:0]    res_q, res_d;
    logic [DIGITS-1:0] err_q, err_d;
    logic            cv_x_q, cv_x_d;
    logic            cv_rst_q, cv_rst_d;

    int              cur_idx;
    int              nxt_idx;
    logic [3:0]      dig;

    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        b_d      = b_q;
        word_d   = word_q;
        res_d    = res_q;
        err_d    = err_q;
        cv_x_d   = 1'b0;
        cv_rst_d = 1'b0;
        dig      = 4'd0;
        cur_idx  = 4 * int'(d_q) + int'(b_q);
        nxt_idx  = 0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d = in_e3;
                    for (int k = 0; k < DIGITS; k++) begin
                        dig      = in_e3[4*k +: 4];
                        err_d[k] = (dig < 4'd3) || (dig > 4'd12);
                    end
                    res_d   = '0;
                    d_d     = '0;
                    state_d = CRST;
                end
            end
            CRST: begin
                b_d     = 2'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Cv_Z is the Mealy output for the bit currently on Cv_X
                for (int k = 0; k < W; k++) begin
                    if (k == cur_idx) begin
                        res_d[k] = Cv_Z;
                    end
                end
                if (b_q != 2'd3) begin
                    b_d = b_q + 2'd1;
                end else if (d_q != D_LAST) begin
                    d_d     = d_q + 1'b1;
                    state_d = CRST;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Converter drive is registered from the next state so it settles just after the edge
        if (state_d == SHIFT) begin
            cv_rst_d = 1'b1;
            nxt_idx  = 4 * int'(d_d) + int'(b_d);
            for (int k = 0; k < W; k++) begin
                if (k == nxt_idx) begin
                    cv_x_d = word_d[k];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            d_q      <= '0;
            b_q      <= 2'd0;
            word_q   <= '0;
            res_q    <= '0;
            err_q    <= '0;
            cv_x_q   <= 1'b0;
            cv_rst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            b_q      <= b_d;
            word_q   <= word_d;
            res_q    <= res_d;
            err_q    <= err_d;
            cv_x_q   <= cv_x_d;
            cv_rst_q <= cv_rst_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_bcd   = res_q;
    assign out_err   = err_q;
    assign Cv_X      = cv_x_q;
    assign Cv_Rst    = cv_rst_q;

endmodule

// File: tb/tb_excess3_digit_sequencer.sv
// Bench for excess3_digit_sequencer with a behavioural serial subtract-3 converter attached.
// Expected results come from per-digit arithmetic (code - 3) and range tests.
module tb_excess3_digit_sequencer;

    localparam int DIGITS = 2;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_e3;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_bcd;
    logic [1:0] out_err;
    logic       busy;
    logic       Cv_X;
    logic       Cv_Rst;
    logic       Cv_Z;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    excess3_digit_sequencer #(.DIGITS(DIGITS)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_e3     (in_e3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .busy      (busy),
        .Cv_X      (Cv_X),
        .Cv_Rst    (Cv_Rst),
        .Cv_Z      (Cv_Z)
    );

    // Serial converter: subtracts 0011 LSB first with a running borrow; Mealy output
    logic [1:0] cv_pos = 2'd0;
    logic       cv_bor = 1'b0;
    logic       sub_bit;
    assign sub_bit = (cv_pos < 2'd2);
    assign Cv_Z    = Cv_X ^ sub_bit ^ cv_bor;

    always @(posedge Clk) begin
        if (!Cv_Rst) begin
            cv_pos <= 2'd0;
            cv_bor <= 1'b0;
        end else begin
            cv_pos <= cv_pos + 2'd1;
            cv_bor <= (!Cv_X && sub_bit) || (!Cv_X && cv_bor) || (sub_bit && cv_bor);
        end
    end

    function automatic logic [1:0] ref_err(input logic [7:0] w);
        logic [1:0] r;
        int c;
        for (int k = 0; k < DIGITS; k++) begin
            c    = int'(w[4*k +: 4]);
            r[k] = (c < 3) || (c > 12);
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_bcd(input logic [7:0] w);
        logic [7:0] r;
        int c;
        for (int k = 0; k < DIGITS; k++) begin
            c          = int'(w[4*k +: 4]);
            r[4*k +: 4] = 4'(c - 3);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Sends one word and completes its output handshake after `stall` cycles of out_ready low
    task automatic run_word(input logic [7:0] w, input logic [7:0] exp_bcd,
                            input logic [1:0] exp_err, input int stall);
        int         lat;
        int         guard;
        logic [9:0] rst_tr;
        logic [9:0] x_tr;
        logic [9:0] rst_exp;
        logic [9:0] x_exp;
        logic [7:0] mask;
        logic [7:0] held;
        bit         busy_ok;
        bit         hold_ok;

        guard = 0;
        while (!in_ready && guard < 30) begin
            tick();
            guard++;
        end
        chk("in_ready_before_send", 32'(in_ready), 32'd1);

        in_valid = 1'b1;
        in_e3    = w;
        tick();
        in_valid = 1'b0;
        in_e3    = 8'($urandom);

        lat     = 0;
        busy_ok = 1'b1;
        rst_tr  = '0;
        x_tr    = '0;
        while (!out_valid && lat < 60) begin
            if (lat < 10) begin
                rst_tr[lat] = Cv_Rst;
                x_tr[lat]   = Cv_X;
            end
            if (!busy || in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd10);
        chk("busy_while_shifting", 32'(busy_ok), 32'd1);

        rst_exp = 10'b11110_11110;
        x_exp   = {w[7:4], 1'b0, w[3:0], 1'b0};
        chk("cv_rst_trace", 32'(rst_tr), 32'(rst_exp));
        chk("cv_x_trace", 32'(x_tr), 32'(x_exp));

        mask = {exp_err[1] ? 4'h0 : 4'hF, exp_err[0] ? 4'h0 : 4'hF};
        chk("out_err", 32'(out_err), 32'(exp_err));
        chk("out_bcd", 32'(out_bcd & mask), 32'(exp_bcd & mask));

        held    = out_bcd;
        hold_ok = 1'b1;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            tick();
            if (!out_valid || in_ready || out_bcd !== held || out_err !== exp_err) hold_ok = 1'b0;
        end
        in_valid = 1'b0;
        if (stall > 0) chk("backpressure_hold", 32'(hold_ok), 32'd1);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_dropped", 32'(out_valid), 32'd0);
        chk("bcd_kept_after_handshake", 32'(out_bcd), 32'(held));
        chk("idle_after_handshake", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [7:0] e3;
        logic [7:0] bcd;
        logic [1:0] err;
        int         stall;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int         lat;
        bit         quiet_ok;
        logic [7:0] w;

        vecs[0] = '{8'hC3, 8'h90, 2'b00, 0};
        vecs[1] = '{8'h55, 8'h22, 2'b00, 0};
        vecs[2] = '{8'h3C, 8'h09, 2'b00, 1};
        vecs[3] = '{8'hF1, 8'h00, 2'b11, 0};
        vecs[4] = '{8'h4B, 8'h18, 2'b00, 5};
        vecs[5] = '{8'h0A, 8'h07, 2'b10, 2};
        vecs[6] = '{8'h2D, 8'h00, 2'b11, 0};
        vecs[7] = '{8'h98, 8'h65, 2'b00, 3};

        Rst       = 1'b1;
        in_valid  = 1'b0;
        in_e3     = 8'h00;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_bcd", 32'(out_bcd), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_cv_rst", 32'(Cv_Rst), 32'd0);
        chk("rst_cv_x", 32'(Cv_X), 32'd0);
        Rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_word(vecs[i].e3, vecs[i].bcd, vecs[i].err, vecs[i].stall);
        end

        for (int a = 3; a <= 12; a++) begin
            for (int b = 3; b <= 12; b++) begin
                w = {4'(b), 4'(a)};
                run_word(w, ref_bcd(w), ref_err(w), 0);
            end
        end

        for (int i = 0; i < 40; i++) begin
            w = 8'($urandom);
            run_word(w, ref_bcd(w), ref_err(w), int'($urandom_range(0, 3)));
        end

        // Back-to-back: in_valid stays high across the output handshake
        in_valid = 1'b1;
        in_e3    = 8'h74;
        tick();
        in_e3 = 8'hA6;
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk("b2b_first_latency", 32'(lat), 32'd10);
        chk("b2b_first_bcd", 32'(out_bcd), 32'h41);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b2b_idle_after_handshake", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_second_accepted", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk("b2b_second_latency", 32'(lat), 32'd10);
        chk("b2b_second_bcd", 32'(out_bcd), 32'h73);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during digit 1, bit 2
        in_valid = 1'b1;
        in_e3    = 8'hC3;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("mid_shift_cv_rst", 32'(Cv_Rst), 32'd1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cv_rst", 32'(Cv_Rst), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_bcd", 32'(out_bcd), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        quiet_ok = 1'b1;
        repeat (15) begin
            tick();
            if (out_valid || busy) quiet_ok = 1'b0;
        end
        chk("midrst_no_output", 32'(quiet_ok), 32'd1);
        run_word(8'h55, 8'h22, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/excess3_digit_sequencer.md
# excess3_digit_sequencer

Controller that feeds a multi-digit Excess-3 word through the shared bit-serial Excess-3-to-BCD converter (`Lab3_Converter_structure`, ports X, Clk, Rst, Z) and assembles the BCD result.
- Accepts a packed word of DIGITS Excess-3 digits on a valid/ready handshake.
- Per digit: pulses the converter's active-low reset, shifts the 4 bits in LSB-first, and samples the Mealy output Z in the same cycle each bit is applied.
- Returns the packed BCD word plus per-digit invalid-code flags on a second valid/ready handshake.
- Sits between a parallel producer and the single converter instance.

## Interface
- DIGITS, default 2: number of 4-bit digits per word; legal range ≥1.
- Clk  in  1  clock; all state changes on posedge.
- Rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word on in_e3.
- in_ready  out  1  sequencer accepts a word this cycle.
- in_e3  in  4*DIGITS  Excess-3 word; digit k at bits [4k+3:4k].
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_bcd  out  4*DIGITS  BCD result, same digit packing as in_e3.
- out_err  out  DIGITS  bit k set if input digit k was outside 3..12.
- busy  out  1  high in every state except IDLE.
- Cv_X  out  1  serial data to converter X.
- Cv_Rst  out  1  converter reset, active-low (0 = hold converter in its initial state).
- Cv_Z  in  1  converter output Z (combinational Mealy output).

## Operation
- States: IDLE, CRST, SHIFT, DONE. Internal counters: digit index d (0..DIGITS-1) and bit index b (0..3).
- IDLE:
  - in_ready=1.
  - On posedge with in_valid: latch in_e3 and compute out_err (digit <3 or >12). Clear the result register, set d=0, go to CRST.
- CRST:
  - Cv_Rst=0, Cv_X=0. Lasts exactly one cycle.
  - Set b=0, go to SHIFT.
- SHIFT:
  - Cv_Rst=1, Cv_X = latched digit d, bit b.
  - At posedge, write Cv_Z into result bit 4d+b.
  - If b<3: b++.
  - If b==3 and d<DIGITS-1: d++, go to CRST.
  - If b==3 and d==DIGITS-1: go to DONE.
- DONE:
  - out_valid=1; out_bcd and out_err hold stable.
  - On posedge with out_ready: go to IDLE. out_valid drops next cycle; out_bcd and out_err keep their last values until the next acceptance.
- Invalid digits are still shifted through unchanged. The BCD value produced for such a digit is whatever the converter emits and is not checked; out_err reports them.
- Cv_Rst=0 and Cv_X=0 in IDLE, CRST and DONE.
- in_ready=0 in every state except IDLE.

## Timing
- Reset: Rst high at a posedge forces IDLE, d=b=0, out_valid=0, out_bcd=0, out_err=0, busy=0, Cv_X=0, Cv_Rst=0.
  - Reset takes priority over every transition, including mid-SHIFT and DONE.
  - A partially shifted word is discarded; no out_valid follows.
- Latency: for a word accepted at posedge E0, out_valid is high from E0 + 5·DIGITS (one CRST plus four SHIFT cycles per digit). For DIGITS=2, out_valid is high after the 10th posedge following acceptance.
- Throughput:
  - in_ready is low in DONE, so a new word is accepted at earliest the posedge after the output handshake. This gives one word per 5·DIGITS+2 cycles with out_ready tied high.
  - in_valid together with out_ready in DONE completes only the output handshake.
- Converter usage:
  - Cv_X and Cv_Rst are registered and change only just after posedge.
  - Cv_Z is sampled at the end of the same SHIFT cycle. The converter state advances on that same edge.
- Backpressure: DONE holds indefinitely while out_ready=0, with outputs stable.
- Input: in_e3 is only sampled at the accepting edge; later changes are ignored.

## Test plan
- Single word, DIGITS=2, in_e3=8'b1100_0011, out_ready=1:
  - Cv_Rst pattern is 0,1,1,1,1,0,1,1,1,1.
  - Cv_X sequence is 1,1,0,0 then 0,0,1,1.
  - out_valid rises 10 cycles after acceptance with out_bcd=8'h90, out_err=2'b00.
- Full sweep: each digit 3..12 in both positions → out_bcd digit = code−3 for all 100 combinations, out_err=0.
- Invalid codes: in_e3=8'b1111_0001 → out_err=2'b11, out_valid still after 10 cycles, busy high throughout.
- Backpressure and back-to-back:
  - out_ready low for 5 cycles in DONE → out_bcd and out_valid held; in_ready=0 throughout.
  - in_valid held high with two words → second word accepted exactly one cycle after the first output handshake.
- Reset mid-operation: Rst=1 during digit 1, bit 2 → next cycle IDLE, Cv_Rst=0, out_valid=0, out_bcd=0. A following word 8'h55 (digits 5,5) → out_bcd=8'h22.
